// File: rtl/tube_pkg.sv
//------------------------------------------------------------------------------
// Module  : tube_pkg
// Purpose : Shared constants for the time-shared seven-segment tube
//           scheduler: segment patterns, digit count, value ceiling, FSM
//           state encoding and decimal-point position encoding.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package tube_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_VAL    = 9999;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 16;

    // Segment patterns, active-high, bit7 = dp, bits6..0 = gfedcba
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    // Scheduler FSM state encoding
    typedef logic [2:0] tube_state_t;
    localparam tube_state_t ST_IDLE   = 3'd0;
    localparam tube_state_t ST_GRANT  = 3'd1;
    localparam tube_state_t ST_CONV   = 3'd2;
    localparam tube_state_t ST_COMMIT = 3'd3;
    localparam tube_state_t ST_HOLD   = 3'd4;

    // Decimal-point position encoding
    localparam logic [1:0] DP_NONE = 2'd0;  // no dp
    localparam logic [1:0] DP_THOU = 2'd1;  // x.xxx
    localparam logic [1:0] DP_HUND = 2'd2;  // xx.xx
    localparam logic [1:0] DP_TENS = 2'd3;  // xxx.x

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tube_bin2bcd.sv
//------------------------------------------------------------------------------
// Module  : tube_bin2bcd
// Purpose : Sequential shift-add-3 (double-dabble) binary to BCD converter.
//           One bit per cycle, fixed 14-cycle latency after i_start.
// Ports   : clk, rstn (async, active-low)
//           i_start  load i_bin and begin conversion
//           i_bin    14-bit binary input (0..9999)
//           o_bcd    16-bit BCD result, valid once o_done has been seen
//           o_done   high during the final shift cycle
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tube_bin2bcd
    import tube_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_done
);

    logic [BIN_W-1:0] r_sh;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic [BCD_W-1:0] w_adj;

    // Add 3 to every BCD nibble of 5 or more before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_sh   <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= 4'(BIN_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // Input is limited to 9999, so the BCD MSB never overflows
            r_bcd <= {w_adj[BCD_W-2:0], r_sh[BIN_W-1]};
            r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == 4'd1);
    assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/tube_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tube_scheduler
// Purpose : Round-robin time-sharing of one 4-digit multiplexed seven-segment
//           tube among N_SRC requesters. The granted value is snapshotted,
//           saturated to 9999, converted to BCD and committed atomically to
//           display registers, which feed a free-running digit scan.
// Config  : TUBE_ZERO_BLANK_EN - when defined, leading zero digits are blanked
//           (stopping at the first nonzero digit, the dp digit, or units).
// Ports   : clk, rstn (async, active-low)
//           i_req[N_SRC]          level display request per source
//           i_data_in[14*N_SRC]   source values
//           i_dp_in[2*N_SRC]      source dp positions
//           o_grant[N_SRC]        one-cycle pulse, source value sampled
//           o_owner               current owner index
//           o_shown               display holds a committed value
//           o_seg[8]              segments, bit7 = dp
//           o_sel[4]              one-hot digit select, sel[0] = units
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tube_scheduler
    import tube_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int SCAN_DIV     = 20000,
    parameter int DWELL_FRAMES = 500
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_SRC-1:0]         i_req,
    input  logic [BIN_W*N_SRC-1:0]   i_data_in,
    input  logic [2*N_SRC-1:0]       i_dp_in,
    output logic [N_SRC-1:0]         o_grant,
    output logic [$clog2(N_SRC)-1:0] o_owner,
    output logic                     o_shown,
    output logic [7:0]               o_seg,
    output logic [3:0]               o_sel
);

    localparam int OW        = $clog2(N_SRC);
    localparam int DWELL_CYC = DWELL_FRAMES * NUM_DIGITS * SCAN_DIV;
    localparam int DW_W      = $clog2(DWELL_CYC);
    localparam int SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    tube_state_t      r_state;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_pick;
    logic [1:0]       r_dp_snap;
    logic [BCD_W-1:0] r_disp;
    logic [1:0]       r_disp_dp;
    logic             r_shown;
    logic [DW_W-1:0]  r_dwell;
    logic [SC_W-1:0]  r_scan;
    logic [1:0]       r_dig;
    logic [3:0]       r_sel;
    logic [7:0]       r_seg;

    logic             w_any;
    logic             w_found;
    logic [OW-1:0]    w_pick;
    logic [BIN_W-1:0] w_raw;
    logic [BIN_W-1:0] w_sat;
    logic [1:0]       w_dp_raw;
    logic             w_start;
    logic             w_done;
    logic [BCD_W-1:0] w_bcd;
    logic             w_expire;
    logic             w_tick;
    logic [1:0]       w_dig_next;
    logic [3:0]       w_digit;
    logic [1:0]       w_dp_dig;
    logic             w_dp_here;
    logic             w_blank;
    logic [7:0]       w_seg_next;

    //--------------------------------------------------------------------------
    // Round-robin search starting at owner+1; the owner itself is checked last
    //--------------------------------------------------------------------------
    assign w_any = |i_req;

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = int'(r_owner) + i;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!w_found && i_req[OW'(idx)]) begin
                w_found = 1'b1;
                w_pick  = OW'(idx);
            end
        end
    end

    // Snapshot mux for the granted source, saturated to the display range
    assign w_raw    = i_data_in[int'(r_pick)*BIN_W +: BIN_W];
    assign w_dp_raw = i_dp_in[int'(r_pick)*2 +: 2];
    assign w_sat    = (w_raw > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : w_raw;
    assign w_start  = (r_state == ST_GRANT);
    assign w_expire = (r_dwell == DW_W'(DWELL_CYC - 1));

    tube_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (w_start),
        .i_bin   (w_sat),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    always_comb begin
        o_grant = '0;
        if (r_state == ST_GRANT) begin
            o_grant[r_pick] = 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Scheduler FSM and dwell counter
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_owner   <= OW'(N_SRC - 1);
            r_pick    <= '0;
            r_dp_snap <= DP_NONE;
            r_disp    <= '0;
            r_disp_dp <= DP_NONE;
            r_shown   <= 1'b0;
            r_dwell   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dwell <= '0;
                    if (w_any) begin
                        r_pick  <= w_pick;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_owner   <= r_pick;
                    r_dp_snap <= w_dp_raw;
                    r_state   <= ST_CONV;
                end
                ST_CONV: begin
                    if (w_done) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_disp    <= w_bcd;
                    r_disp_dp <= r_dp_snap;
                    r_shown   <= 1'b1;
                    r_dwell   <= '0;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    // A dropped owner request only cuts the dwell short when
                    // someone else is waiting; otherwise the value is kept.
                    if (w_any && (w_expire || !i_req[r_owner])) begin
                        r_pick  <= w_pick;
                        r_dwell <= '0;
                        r_state <= ST_GRANT;
                    end else if (w_expire) begin
                        r_dwell <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Digit scan: free-running, loads the pattern of the digit being selected
    //--------------------------------------------------------------------------
    assign w_tick     = (r_scan == SC_W'(SCAN_DIV - 1));
    assign w_dig_next = r_dig + 2'd1;
    assign w_digit    = r_disp[int'(w_dig_next)*4 +: 4];
    // dp position p lands on digit index 4-p (thousands = 3), i.e. -p mod 4
    assign w_dp_dig   = 2'd0 - r_disp_dp;
    assign w_dp_here  = (r_disp_dp != DP_NONE) && (w_dp_dig == w_dig_next);

`ifdef TUBE_ZERO_BLANK_EN
    logic [3:0] w_lead;
    logic [3:0] w_dp_at;

    // w_lead[d]: digits d..3 are zero and none of them carries the dp
    always_comb begin
        w_dp_at = '0;
        if (r_disp_dp != DP_NONE) begin
            w_dp_at[w_dp_dig] = 1'b1;
        end
        w_lead[3] = (r_disp[15:12] == 4'd0) && !w_dp_at[3];
        w_lead[2] = w_lead[3] && (r_disp[11:8] == 4'd0) && !w_dp_at[2];
        w_lead[1] = w_lead[2] && (r_disp[7:4] == 4'd0) && !w_dp_at[1];
        w_lead[0] = 1'b0;
    end

    assign w_blank = w_lead[w_dig_next];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg_next = SEG_BLANK;
        if (r_shown && !w_blank) begin
            w_seg_next = seg_of(w_digit) | (w_dp_here ? SEG_DP : SEG_BLANK);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scan <= '0;
            r_dig  <= 2'd0;
            r_sel  <= 4'b0001;
            r_seg  <= SEG_BLANK;
        end else if (w_tick) begin
            r_scan <= '0;
            r_dig  <= w_dig_next;
            r_sel  <= {r_sel[2:0], r_sel[3]};
            r_seg  <= w_seg_next;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign o_owner = r_owner;
    assign o_shown = r_shown;
    assign o_seg   = r_seg;
    assign o_sel   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_tube_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_tube_scheduler
// Purpose : Directed self-checking bench for tube_scheduler (4 sources,
//           short scan and dwell so that every scenario fits a short run).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tube_scheduler;

    localparam int N_SRC        = 4;
    localparam int SCAN_DIV     = 4;
    localparam int DWELL_FRAMES = 2;

`ifdef TUBE_ZERO_BLANK_EN
    localparam logic [31:0] EXP_42 = 32'h0000665B;
    localparam logic [31:0] EXP_0  = 32'h0000003F;
`else
    localparam logic [31:0] EXP_42 = 32'h3F3F665B;
    localparam logic [31:0] EXP_0  = 32'h3F3F3F3F;
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [N_SRC-1:0]     req;
    logic [14*N_SRC-1:0]  data_in;
    logic [2*N_SRC-1:0]   dp_in;
    logic [N_SRC-1:0]     grant;
    logic [1:0]           owner;
    logic                 shown;
    logic [7:0]           seg;
    logic [3:0]           sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_g2   = 1'b0;
    bit g2_seen  = 1'b0;

    always #5 clk = ~clk;

    tube_scheduler #(
        .N_SRC        (N_SRC),
        .SCAN_DIV     (SCAN_DIV),
        .DWELL_FRAMES (DWELL_FRAMES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (req),
        .i_data_in (data_in),
        .i_dp_in   (dp_in),
        .o_grant   (grant),
        .o_owner   (owner),
        .o_shown   (shown),
        .o_seg     (seg),
        .o_sel     (sel)
    );

    always @(negedge clk) begin
        if (mon_g2 && grant[2]) g2_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int s, input int val, input int dp);
        data_in[s*14 +: 14] = 14'(val);
        dp_in[s*2 +: 2]     = 2'(dp);
    endtask

    // Returns the granted source index, or -1 if no grant within budget
    task automatic wait_grant(input int budget, output int idx);
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                for (int k = 0; k < N_SRC; k++) if (grant[k]) idx = k;
                break;
            end
        end
    endtask

    // Frame packed as {thousands, hundreds, tens, units}
    task automatic sample_frame(output logic [31:0] f);
        f = 32'hEEEEEEEE;
        repeat (4*SCAN_DIV) begin
            @(negedge clk);
            case (sel)
                4'b1000: f[31:24] = seg;
                4'b0100: f[23:16] = seg;
                4'b0010: f[15:8]  = seg;
                4'b0001: f[7:0]   = seg;
                default: f        = 32'hBADBAD00;
            endcase
        end
    endtask

    task automatic show_value(input int src, input int val, input int dp,
                              input logic [31:0] exp, input string tag);
        int          idx;
        logic [31:0] f;
        set_src(src, val, dp);
        req = 4'(1 << src);
        wait_grant(120, idx);
        chk({tag, "_grant"}, idx, src);
        repeat (16 + SCAN_DIV + 1) @(negedge clk);
        sample_frame(f);
        chk({tag, "_frame"}, f, exp);
    endtask

    initial begin
        int          idx;
        int          exp_seq [4];
        bit          anyg;
        logic [31:0] f;

        rstn    = 1'b0;
        req     = '0;
        data_in = '0;
        dp_in   = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg",   seg,   8'h00);
        chk("rst_sel",   sel,   4'b0001);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_shown", shown, 1'b0);
        chk("rst_owner", owner, 2'd3);

        // First grant, commit latency and scan pattern
        rstn = 1'b1;
        set_src(0, 1234, 1);
        req = 4'b0001;
        wait_grant(10, idx);
        chk("first_grant", idx, 0);
        @(negedge clk);
        chk("grant_pulse", grant, 4'b0000);
        chk("owner0", owner, 2'd0);
        repeat (14) @(negedge clk);
        chk("shown_t15", shown, 1'b0);
        @(negedge clk);
        chk("shown_t16", shown, 1'b1);
        repeat (SCAN_DIV + 1) @(negedge clk);
        sample_frame(f);
        chk("frame_1234", f, 32'h865B4F66);

        // Reset in the middle of a refresh conversion
        set_src(0, 12000, 0);
        wait_grant(120, idx);
        chk("refresh_grant", idx, 0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midconv_seg",   seg,   8'h00);
        chk("midconv_sel",   sel,   4'b0001);
        chk("midconv_grant", grant, 4'b0000);
        chk("midconv_shown", shown, 1'b0);
        chk("midconv_owner", owner, 2'd3);
        req = '0;
        @(negedge clk);
        rstn = 1'b1;
        anyg = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (grant != '0) anyg = 1'b1;
        end
        chk("idle_no_grant", anyg, 1'b0);
        chk("idle_shown", shown, 1'b0);

        // Saturation
        show_value(0, 12000, 0, 32'h6F6F6F6F, "sat");

        // Round robin over 1011 starting from owner 0
        set_src(1, 1111, 0);
        set_src(3, 3333, 0);
        mon_g2 = 1'b1;
        req = 4'b1011;
        exp_seq = '{1, 3, 0, 1};
        for (int i = 0; i < 4; i++) begin
            wait_grant(120, idx);
            chk($sformatf("rr_grant%0d", i), idx, exp_seq[i]);
        end
        mon_g2 = 1'b0;
        chk("rr_no_grant2", g2_seen, 1'b0);

        // Owner 0 drops while source 2 waits: dwell cut short
        req = 4'b0001;
        wait_grant(120, idx);
        chk("cut_setup_grant", idx, 0);
        repeat (20) @(negedge clk);
        set_src(2, 42, 0);
        req = 4'b0100;
        wait_grant(2, idx);
        chk("cut_grant", idx, 2);

        // Owner drops with nobody else waiting: value held, no grant
        repeat (20) @(negedge clk);
        req = '0;
        anyg = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (grant != '0) anyg = 1'b1;
        end
        chk("held_no_grant", anyg, 1'b0);
        chk("held_shown", shown, 1'b1);
        sample_frame(f);
        chk("held_42", f, EXP_42);

        // Leading-zero behaviour
        show_value(2, 0, 0, EXP_0, "zero");
        show_value(2, 42, 1, 32'hBF3F665B, "dp42");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tube_scheduler.md
# tube_scheduler

Time-shares the 4-digit multiplexed seven-segment tube among N_SRC requesters. Each requester presents a 14-bit binary value (0..9999) and a decimal-point position. The block grants the display to one requester at a time in round-robin order, holds it for a programmable dwell, and converts the snapshot to BCD with a sequential double-dabble. It then drives the digit scan: segment and one-hot select lines. It replaces per-source tube instances at the top level.

## Interface
- N_SRC, 4: number of requesters (2..8).
- SCAN_DIV, 20000: clk cycles per digit slot.
- DWELL_FRAMES, 500: full 4-digit scan frames per ownership slot.
- clk  in  1  system clock.
- rstn  in  1  reset rstn, asynchronous, active-low; clock clk.
- req  in  N_SRC  per-source display request, level.
- data_in  in  14*N_SRC  source i value at bits [14i+13:14i].
- dp_in  in  2*N_SRC  per source: 0 no dp, 1 x.xxx, 2 xx.xx, 3 xxx.x.
- grant  out  N_SRC  one-cycle pulse: value of source i sampled this edge.
- owner  out  clog2(N_SRC)  index of current owner.
- shown  out  1  display holds a committed value.
- seg  out  8  segments, active-high, bit7 = dp, bits6..0 = gfedcba.
- sel  out  4  one-hot digit select; sel[3] thousands … sel[0] units.

## Operation
- FSM states: IDLE, GRANT, CONV, COMMIT, HOLD.
- IDLE: wait for any req. The arbiter searches from owner+1 mod N_SRC for the first set req, then goes to GRANT.
- GRANT (1 cycle):
  - assert grant[k];
  - owner <= k;
  - capture data_in[k] and dp_in[k];
  - values above 9999 saturate to 9999.
- CONV (14 cycles): shift-add-3 double-dabble in sub-module tube_bin2bcd.
- COMMIT (1 cycle): copy 4 BCD digits and dp position to display registers atomically; shown <= 1.
- HOLD: count completed frames from commit.
  - Expiry at DWELL_FRAMES: re-arbitrate. The search may return the same owner, which refreshes its value. If no req is set, return to IDLE and keep the display.
  - Owner req deasserted and another req set: re-arbitrate on the next cycle (dwell cut short).
  - Owner req deasserted and no other req: stay in HOLD, keep the value.
- Reset values: owner = N_SRC-1, so the first search starts at 0.
- Requests arriving during GRANT, CONV or COMMIT are ignored until the next arbitration point. Display registers never change mid-conversion.
- Segment patterns, dp clear: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Blank = 00.
- dp bit set on digit: thousands for pos 1, hundreds for pos 2, tens for pos 3.
- shown=0: seg = 00 on all digits.

## Timing
- Scan counter runs 0..SCAN_DIV-1. A tick occurs at terminal count.
- On each tick, sel rotates 0001→0010→0100→1000→0001 and seg loads the pattern for the newly selected digit. Both outputs are registered.
- Latency: grant at cycle t, commit at t+15, display registers valid at t+16. The new value is visible from the first scan tick after t+16.
- A frame is 4 ticks. Dwell = DWELL_FRAMES × 4 × SCAN_DIV clk cycles from commit.
- Scan runs continuously in all FSM states. It is not reset by arbitration.
- Reset (async, any state, including mid-CONV):
  - state IDLE;
  - grant=0, shown=0, seg=00, sel=0001;
  - scan and dwell counters 0;
  - an in-progress conversion is discarded.

## Configuration
- TUBE_ZERO_BLANK_EN defined: leading zero digits show 00.
  - Blanking scans from thousands downward.
  - It stops at the first nonzero digit, at the digit carrying the dp, or at units, whichever comes first.
  - Units is never blanked.
- Undefined: all four digits are always displayed, including leading zeros.

## Structure
- Package tube_pkg:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - NUM_DIGITS = 4;
  - MAX_VAL = 9999;
  - FSM state enum;
  - dp-position encoding constants.
- Sub-module tube_bin2bcd:
  - start/done interface;
  - 14-bit in, 16-bit BCD out;
  - fixed 14-cycle latency.
- Arbiter, FSM, dwell counter and scan live in tube_scheduler.

## Test plan
- Reset: hold rstn low mid-CONV → seg=00, sel=0001, grant=0, shown=0. Release → IDLE.
- req=0001, data0=1234, dp0=1 → grant[0] one cycle, shown=1 at t+16. Scan: sel=1000 seg=86, 0100 seg=5B, 0010 seg=4F, 0001 seg=66.
- data0=12000 → displays 9999 (seg=6F on all four digits).
- req=1011, owner=0 → successive grants at dwell expiries: 1, 3, 0, 1. No grant[2].
- Owner 0 drops req mid-HOLD while req[2]=1 → grant[2] within 2 cycles. Only req[0] drops → value held, no grant.
- TUBE_ZERO_BLANK_EN defined:
  - 0042, dp=0 → 00, 00, 66, 5B;
  - 0 → 00, 00, 00, 3F;
  - 0042, dp=1 → BF, 3F, 66, 5B.
  - Undefined: 0042 → 3F, 3F, 66, 5B.
